// File: rtl/data_path_muxs_pkg.sv
// Shared datapath mux encodings and the in-flight write tracker entry type.
package data_path_muxs_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  localparam int unsigned FWD_SEL_REGFILE = 0;
  localparam int unsigned FWD_SEL_EXMEM   = 1;
  localparam int unsigned FWD_SEL_MEMWB   = 2;

  typedef struct packed {
    logic     valid;
    regbits_t dest;
    logic     is_load;
  } fwd_entry_t;

endpackage

// File: rtl/forward_port_match.sv
// Priority matcher for one source operand: finds the youngest checked entry
// that writes the operand's register and reports its index and load flag.
module forward_port_match
  import data_path_muxs_pkg::*;
#(
  parameter int unsigned NCHK  = 2,
  parameter int unsigned SEL_W = 2
) (
  input  fwd_entry_t [NCHK-1:0] i_entries,
  input  regbits_t              i_src,
  input  logic                  i_used,
  output logic                  o_hit,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_is_load
);

  // Oldest-to-youngest scan so the lowest index wins; $0 never matches.
  always_comb begin
    o_hit     = 1'b0;
    o_idx     = '0;
    o_is_load = 1'b0;
    for (int j = int'(NCHK) - 1; j >= 0; j--) begin
      if (i_used && i_entries[j].valid && (i_entries[j].dest == i_src) &&
          (i_entries[j].dest != '0)) begin
        o_hit     = 1'b1;
        o_idx     = SEL_W'(j);
        o_is_load = i_entries[j].is_load;
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding / load-use hazard unit with registered operand selects.
// Optional stall-cycle counter built only when FWD_STALL_COUNT_EN is defined.
module forward_scoreboard
  import data_path_muxs_pkg::*;
#(
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NSTAGES  = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned SEL_W    = $clog2(NSTAGES + 1)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        pipe_en,
  input  logic                        flush,
  input  logic [NREAD-1:0][REG_W-1:0] id_src,
  input  logic [NREAD-1:0]            id_src_used,
  input  logic                        id_wen,
  input  regbits_t                    id_dest,
  input  logic                        id_is_load,
  output logic                        hazard_stall,
  output logic [NREAD-1:0][SEL_W-1:0] fwd_sel,
  output logic [31:0]                 stall_count
);

  // The last stage (WB) is never checked and leaves at the next advance,
  // so only the first NSTAGES-1 entries need storage.
  localparam int unsigned NCHK = NSTAGES - 1;

  fwd_entry_t [NCHK-1:0]         r_entries;
  logic [NREAD-1:0][SEL_W-1:0]   r_fwd_sel;
  logic [NREAD-1:0]              w_hit;
  logic [NREAD-1:0]              w_is_load;
  logic [NREAD-1:0][SEL_W-1:0]   w_idx;
  logic [NREAD-1:0]              w_op_stall;
  logic [NREAD-1:0][SEL_W-1:0]   w_next_sel;
  logic                          w_bubble;

  for (genvar g = 0; g < NREAD; g++) begin : g_match
    forward_port_match #(
      .NCHK  (NCHK),
      .SEL_W (SEL_W)
    ) u_match (
      .i_entries (r_entries),
      .i_src     (id_src[g]),
      .i_used    (id_src_used[g]),
      .o_hit     (w_hit[g]),
      .o_idx     (w_idx[g]),
      .o_is_load (w_is_load[g])
    );
  end

  // Per-operand stall and next select; a load in entry j is usable once j >= LOAD_LAT.
  always_comb begin
    w_op_stall = '0;
    w_next_sel = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      w_next_sel[i] = SEL_W'(FWD_SEL_REGFILE);
      if (FWD_EN != 0) begin
        w_op_stall[i] = w_hit[i] && w_is_load[i] && (32'(w_idx[i]) < LOAD_LAT);
        if (w_hit[i]) w_next_sel[i] = w_idx[i] + SEL_W'(1);
      end else begin
        w_op_stall[i] = w_hit[i];
      end
    end
  end

  assign hazard_stall = (|w_op_stall) && !flush;
  assign w_bubble     = hazard_stall || flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_entries <= '0;
      r_fwd_sel <= '0;
    end else if (pipe_en) begin
      for (int k = int'(NCHK) - 1; k > 0; k--) r_entries[k] <= r_entries[k-1];
      if (w_bubble) begin
        r_entries[0] <= '0;
        r_fwd_sel    <= '0;
      end else begin
        r_entries[0] <= fwd_entry_t'{valid: id_wen, dest: id_dest, is_load: id_is_load};
        r_fwd_sel    <= w_next_sel;
      end
    end
  end

  assign fwd_sel = r_fwd_sel;

`ifdef FWD_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  // Saturating count of cycles the pipeline actually stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_stall_count <= '0;
    else if (pipe_en && hazard_stall && (r_stall_count != '1))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: FWD_EN=0 and FWD_EN=1 instances share stimulus,
// each checked every cycle against a pipeline-occupancy model.
module tb_forward_scoreboard;

  localparam int unsigned NREAD    = 2;
  localparam int unsigned NSTAGES  = 3;
  localparam int unsigned LOAD_LAT = 1;
  localparam int unsigned SEL_W    = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic                        pipe_en, flush, id_wen, id_is_load;
  logic [NREAD-1:0][4:0]       id_src;
  logic [NREAD-1:0]            id_src_used;
  logic [4:0]                  id_dest;
  logic                        hz0, hz1;
  logic [NREAD-1:0][SEL_W-1:0] fs0, fs1;
  logic [31:0]                 sc0, sc1;

  forward_scoreboard #(.NREAD(NREAD), .NSTAGES(NSTAGES), .LOAD_LAT(LOAD_LAT), .FWD_EN(0)) dut0 (
    .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush), .id_src(id_src),
    .id_src_used(id_src_used), .id_wen(id_wen), .id_dest(id_dest), .id_is_load(id_is_load),
    .hazard_stall(hz0), .fwd_sel(fs0), .stall_count(sc0));

  forward_scoreboard #(.NREAD(NREAD), .NSTAGES(NSTAGES), .LOAD_LAT(LOAD_LAT), .FWD_EN(1)) dut1 (
    .CLK(CLK), .RST(RST), .pipe_en(pipe_en), .flush(flush), .id_src(id_src),
    .id_src_used(id_src_used), .id_wen(id_wen), .id_dest(id_dest), .id_is_load(id_is_load),
    .hazard_stall(hz1), .fwd_sel(fs1), .stall_count(sc1));

  // Model: contents of EX, MEM, WB for each mode (index 0 = stall-only, 1 = forwarding).
  typedef struct {bit v; int d; bit ld;} ent_t;
  ent_t        m     [2][NSTAGES];
  int          m_sel [2][NREAD];
  int unsigned m_cnt [2];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      for (int k = 0; k < int'(NSTAGES); k++) m[md][k] = '{0, 0, 0};
      for (int i = 0; i < int'(NREAD); i++) m_sel[md][i] = 0;
      m_cnt[md] = 0;
    end
  endtask

  // Youngest writer still in EX/MEM decides; WB is already in the regfile.
  function automatic void op_eval(input int md, input int i, output bit st, output int sel);
    st  = 0;
    sel = 0;
    if (!id_src_used[i] || id_src[i] == 5'd0) return;
    for (int j = 0; j < int'(NSTAGES) - 1; j++) begin
      if (m[md][j].v && m[md][j].d == int'(id_src[i])) begin
        if (md == 1) begin
          st  = m[md][j].ld && (j < int'(LOAD_LAT));
          sel = j + 1;
        end else begin
          st = 1;
        end
        return;
      end
    end
  endfunction

  task automatic drive(input bit pe, input bit fl, input int s0, input bit u0, input int s1,
                       input bit u1, input bit w, input int d, input bit l);
    pipe_en = pe; flush = fl;
    id_src[0] = 5'(s0); id_src_used[0] = u0;
    id_src[1] = 5'(s1); id_src_used[1] = u1;
    id_wen = w; id_dest = 5'(d); id_is_load = l;
    #1;
  endtask

  // One cycle: compare both DUTs on the falling edge, advance the model on the rising edge.
  task automatic tick();
    bit st [2];
    int sl [2][NREAD];
    bit s;
    int v;
    @(negedge CLK);
    for (int md = 0; md < 2; md++) begin
      st[md] = 0;
      for (int i = 0; i < int'(NREAD); i++) begin
        op_eval(md, i, s, v);
        st[md] = st[md] | s;
        sl[md][i] = v;
      end
      st[md] = st[md] & !flush;
    end
    chk("stall_m0", 64'(hz0), 64'(st[0]));
    chk("stall_m1", 64'(hz1), 64'(st[1]));
    for (int i = 0; i < int'(NREAD); i++) begin
      chk($sformatf("sel_m0_op%0d", i), 64'(fs0[i]), 64'(m_sel[0][i]));
      chk($sformatf("sel_m1_op%0d", i), 64'(fs1[i]), 64'(m_sel[1][i]));
    end
    chk("count_m0", 64'(sc0), 64'(m_cnt[0]));
    chk("count_m1", 64'(sc1), 64'(m_cnt[1]));
    @(posedge CLK);
    if (pipe_en) begin
      for (int md = 0; md < 2; md++) begin
        for (int k = int'(NSTAGES) - 1; k > 0; k--) m[md][k] = m[md][k-1];
        if (st[md] || flush) begin
          m[md][0] = '{0, 0, 0};
          for (int i = 0; i < int'(NREAD); i++) m_sel[md][i] = 0;
        end else begin
          m[md][0] = '{id_wen, int'(id_dest), id_is_load};
          for (int i = 0; i < int'(NREAD); i++) m_sel[md][i] = sl[md][i];
        end
`ifdef FWD_STALL_COUNT_EN
        if (st[md]) m_cnt[md]++;
`endif
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] saved;
    RST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_stall", 64'(hz1), 64'd0);
    chk("reset_sel", 64'(fs1), 64'd0);
    chk("reset_count", 64'(sc1), 64'd0);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK) #1;

    // ALU producer in EX forwards from EX/MEM
    drive(1, 0, 0, 0, 0, 0, 1, 3, 0); tick();
    drive(1, 0, 3, 1, 0, 0, 0, 0, 0);
    chk("alu_no_stall", 64'(hz1), 64'd0);
    tick();
    chk("alu_sel_exmem", 64'(fs1[0]), 64'd1);

    // Load-use: one stall, then MEM/WB forward
    drive(1, 0, 0, 0, 0, 0, 1, 4, 1); tick();
    drive(1, 0, 4, 1, 0, 0, 1, 11, 0);
    chk("lu_stall", 64'(hz1), 64'd1);
    tick();
    chk("lu_bubble_sel", 64'(fs1[0]), 64'd0);
    chk("lu_no_stall_2nd", 64'(hz1), 64'd0);
    tick();
    chk("lu_sel_memwb", 64'(fs1[0]), 64'd2);

    // Two writers of $5: youngest wins; $0 never forwards
    drive(1, 0, 0, 0, 0, 0, 1, 5, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 1, 5, 0); tick();
    drive(1, 0, 5, 1, 0, 1, 0, 0, 0);
    chk("dup_no_stall", 64'(hz1), 64'd0);
    tick();
    chk("dup_sel_youngest", 64'(fs1[0]), 64'd1);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
    chk("r0_no_stall", 64'(hz1), 64'd0);
    tick();
    chk("r0_sel", 64'(fs1), 64'd0);

    // Stall-only mode: writer in MEM stalls until it reaches WB
    drive(1, 0, 0, 0, 0, 0, 1, 6, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 6, 1, 0, 0, 0);
    chk("so_stall_m0", 64'(hz0), 64'd1);
    chk("so_fwd_m1", 64'(hz1), 64'd0);
    tick();
    chk("so_m1_sel_memwb", 64'(fs1[1]), 64'd2);
    chk("so_released", 64'(hz0), 64'd0);
    tick();
    chk("so_sel_zero", 64'(fs0), 64'd0);

    // Flush beats a load-use hazard
    drive(1, 0, 0, 0, 0, 0, 1, 7, 1); tick();
    drive(1, 1, 7, 1, 0, 0, 1, 12, 0);
    chk("flush_no_stall", 64'(hz1), 64'd0);
    tick();
    chk("flush_sel", 64'(fs1), 64'd0);

    // Held pipeline keeps stalling without counting
    drive(1, 0, 0, 0, 0, 0, 1, 8, 1); tick();
    saved = sc1;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 8, 1, 0, 0, 0, 0, 0);
      chk("hold_stall", 64'(hz1), 64'd1);
      tick();
    end
    chk("hold_count", 64'(sc1), 64'(saved));
    drive(1, 0, 8, 1, 0, 0, 0, 0, 0); tick();
    tick();

    // Asynchronous reset in the middle of a stall
    drive(1, 0, 0, 0, 0, 0, 1, 3, 0); tick();
    drive(1, 0, 3, 1, 0, 0, 1, 9, 1); tick();
    chk("pre_rst_sel", 64'(fs1[0]), 64'd1);
    drive(1, 0, 9, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", 64'(hz1), 64'd1);
    #1 RST = 1'b1;
    #1;
    chk("rst_stall", 64'(hz1), 64'd0);
    chk("rst_sel", 64'(fs1), 64'd0);
    chk("rst_count", 64'(sc1), 64'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK) #1;

`ifdef FWD_STALL_COUNT_EN
    // Five load-use pairs give five stall cycles
    for (int c = 0; c < 5; c++) begin
      drive(1, 0, 0, 0, 0, 0, 1, 10, 1); tick();
      drive(1, 0, 10, 1, 0, 0, 0, 0, 0); tick();
      tick();
    end
    chk("count_five", 64'(sc1), 64'd5);
`endif

    // Randomized traffic over a small register set to force frequent matches
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined datapath, succeeding the combinational forward unit. It tracks in-flight register writes in an internal shift register, resolves forwarding for NREAD source operands one cycle early and registers the selects for the EX stage. It raises a stall when the youngest producer's data cannot be ready in time. It sits beside the ID/EX latch and drives the ALU/store-data operand muxes and the hazard path.

## Interface
Parameters:
- NREAD, 2, number of source operands tracked per instruction
- NSTAGES, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB)
- LOAD_LAT, 1, stages after EX before load data is forwardable
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode
- SEL_W, $clog2(NSTAGES+1), width of each select

Ports:
- CLK  in  1  system clock; only clock
- RST  in  1  asynchronous, active-high reset
- pipe_en  in  1  pipeline advances this cycle (low during memory wait)
- flush  in  1  instruction in ID is killed at this advance
- id_src  in  NREAD×5  source register numbers of the ID instruction
- id_src_used  in  NREAD  operand actually read (e.g. rt of I-type ALU = 0)
- id_wen  in  1  ID instruction writes a register
- id_dest  in  5  its destination register
- id_is_load  in  1  ID instruction is LW
- hazard_stall  out  1  combinational; hold PC/IF-ID, bubble into EX
- fwd_sel  out  NREAD×SEL_W  registered; per operand, 0 = regfile, k = latch of entry k (1 = EX/MEM, 2 = MEM/WB)
- stall_count  out  32  stall-cycle counter (see Configuration)

## Operation
- Each entry holds {valid, dest, is_load}. Entries with dest == 0 are never matched.
- Match for operand i: the lowest-index valid entry j < NSTAGES-1 with dest == id_src[i] and id_src_used[i]. The last entry leaves at the advance and is not checked; the regfile writes first half-cycle.
- FWD_EN=1: an operand needs a stall if its match is a load and j+1 < LOAD_LAT+1. Otherwise its next select is j+1; with no match, it is 0.
- FWD_EN=0: any match stalls; selects are always 0.
- hazard_stall = OR over operands of the per-operand stall condition, gated by !flush.
- Advance when pipe_en=1:
  - Entries shift (entry k → k+1); the last entry is discarded.
  - If hazard_stall or flush: entry 0 ← bubble (valid=0) and fwd_sel ← 0.
  - Otherwise: entry 0 ← {id_wen, id_dest, id_is_load} and fwd_sel ← computed selects.
- pipe_en=0: all state holds. hazard_stall is still evaluated.
- flush and hazard_stall together: flush wins; no stall, bubble is pushed.

## Timing
- Reset (async, RST=1): all entries invalid, fwd_sel = 0, stall_count = 0. hazard_stall is therefore 0.
- fwd_sel is valid the cycle after the advance that moved the instruction from ID into EX. Latency is 1 cycle.
- hazard_stall is combinational from id_* inputs and current entries, with no registered delay.
- Load-use with LOAD_LAT=1 produces exactly one stall cycle. The load advances to MEM, and the consumer then gets select 2 (MEM/WB).
- Reset asserted mid-stall clears the stall immediately; the pipeline resumes from an empty tracker.

## Configuration
- FWD_STALL_COUNT_EN defined: stall_count increments by 1 on every cycle with pipe_en & hazard_stall. It saturates at 32'hFFFF_FFFF.
- Not defined: no counter logic is built, and stall_count is tied to 0.

## Structure
- data_path_muxs_pkg gains:
  - FWD_SEL_REGFILE = 0, FWD_SEL_EXMEM = 1, FWD_SEL_MEMWB = 2
  - typedef fwd_entry_t {logic valid; regbits_t dest; logic is_load;}
- One sub-module, forward_port_match: a per-operand priority matcher that returns the hit, its index and the is_load flag. It is instantiated NREAD times via generate.

## Test plan
- add $3 in EX, ID reads $3 as rs → no stall; after advance fwd_sel[0]=1.
- lw $4 in EX, ID add uses $4 (LOAD_LAT=1) → hazard_stall=1 one cycle, bubble pushed; next cycle no stall; after advance fwd_sel=2.
- Write to $5 in both EX and MEM, ID reads $5 → youngest chosen, fwd_sel=1; ID src $0 with EX dest $0 → fwd_sel=0, no stall.
- FWD_EN=0, add $6 in MEM, ID reads $6 → stall until the writer reaches WB, then fwd_sel=0.
- Load-use hazard with flush=1 → hazard_stall=0, bubble pushed, fwd_sel=0. Load-use hazard with pipe_en=0 for 3 cycles → entries hold, stall_count unchanged.
- RST pulsed mid-stall (async, between edges) → hazard_stall and fwd_sel drop to 0 at once. With FWD_STALL_COUNT_EN, 5 stall cycles give stall_count=5.
